// File: rtl/permutation_ctrl.sv
// permutation_ctrl: round sequencer for the ASCON permutation datapath.
// On start_i it issues data_sel/round/en_reg_state for a p12 (mode_i=0) or
// p6 (mode_i=1) permutation, then pulses done_o for one cycle.
//
// Optional build macro: PERMUTATION_CTRL_PERF_CNT_EN
//   defined   -> perm_cnt_o counts completed permutations, saturating.
//   undefined -> perm_cnt_o is tied to zero.
//
// Ports:
//   clock_i         system clock, rising edge
//   resetb_i        asynchronous active-low reset
//   start_i         permutation request (pulse or level)
//   mode_i          0 = pa (ROUNDS_A rounds), 1 = pb (ROUNDS_B rounds)
//   data_sel_o      0 = datapath takes external state, 1 = feedback
//   round_o         round constant index 0..11
//   en_reg_state_o  datapath state register load enable
//   busy_o          high while rounds are being issued
//   done_o          one-cycle completion pulse
//   perm_cnt_o      completed-permutation count
module permutation_ctrl #(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 6,
   parameter int unsigned PERF_W   = 16
) (
   input  logic              clock_i,
   input  logic              resetb_i,
   input  logic              start_i,
   input  logic              mode_i,
   output logic              data_sel_o,
   output logic [3:0]        round_o,
   output logic              en_reg_state_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [PERF_W-1:0] perm_cnt_o
);

   localparam int unsigned RND_W    = 4;
   localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(11);
   localparam logic [RND_W-1:0] START_A    = RND_W'(12 - ROUNDS_A);
   localparam logic [RND_W-1:0] START_B    = RND_W'(12 - ROUNDS_B);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [RND_W-1:0] round_d;
   logic             data_sel_d;
   logic             en_d;
   logic             busy_d;
   logic             done_d;

   // Next state and next round; mode_i is consumed only as the start round,
   // so the round counter itself carries the latched mode.
   always_comb begin
      state_d    = state_q;
      round_d    = round_o;
      data_sel_d = 1'b0;
      en_d       = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = FIRST;
               round_d = mode_i ? START_B : START_A;
            end else begin
               state_d = IDLE;
            end
         end
         FIRST, RUN: begin
            if (round_o == LAST_ROUND) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
               round_d = RND_W'(round_o + RND_W'(1));
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state and registered alongside it.
      en_d       = (state_d == FIRST) || (state_d == RUN);
      busy_d     = en_d;
      data_sel_d = (state_d == RUN) || (state_d == DONE);
      done_d     = (state_d == DONE);
   end

   // State and registered control outputs.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q        <= IDLE;
         round_o        <= '0;
         data_sel_o     <= 1'b0;
         en_reg_state_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         state_q        <= state_d;
         round_o        <= round_d;
         data_sel_o     <= data_sel_d;
         en_reg_state_o <= en_d;
         busy_o         <= busy_d;
         done_o         <= done_d;
      end
   end

`ifdef PERMUTATION_CTRL_PERF_CNT_EN
   // Saturating completion counter, updated together with done_o.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         perm_cnt_o <= '0;
      end else if (done_d && (perm_cnt_o != {PERF_W{1'b1}})) begin
         perm_cnt_o <= PERF_W'(perm_cnt_o + PERF_W'(1));
      end
   end
`else
   assign perm_cnt_o = '0;
`endif

endmodule

// File: tb/tb_permutation_ctrl.sv
// Directed testbench for permutation_ctrl (PERF_W = 2 so saturation is reachable).
module tb_permutation_ctrl;

   localparam int unsigned PERF_W = 2;

   logic              clock_i  = 1'b0;
   logic              resetb_i = 1'b0;
   logic              start_i  = 1'b0;
   logic              mode_i   = 1'b0;
   logic              data_sel_o;
   logic [3:0]        round_o;
   logic              en_reg_state_o;
   logic              busy_o;
   logic              done_o;
   logic [PERF_W-1:0] perm_cnt_o;

   int tests = 0;
   int fails = 0;
   logic [PERF_W-1:0] exp_cnt = '0;

   permutation_ctrl #(
      .ROUNDS_A(12),
      .ROUNDS_B(6),
      .PERF_W  (PERF_W)
   ) dut (
      .clock_i       (clock_i),
      .resetb_i      (resetb_i),
      .start_i       (start_i),
      .mode_i        (mode_i),
      .data_sel_o    (data_sel_o),
      .round_o       (round_o),
      .en_reg_state_o(en_reg_state_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .perm_cnt_o    (perm_cnt_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   // Expected count after a completed permutation.
   task automatic bump();
`ifdef PERMUTATION_CTRL_PERF_CNT_EN
      if (exp_cnt != {PERF_W{1'b1}}) exp_cnt = PERF_W'(exp_cnt + PERF_W'(1));
`endif
   endtask

   task automatic check(input string tag, input logic e_en, input logic e_ds,
                        input logic chk_round, input logic [3:0] e_round,
                        input logic e_busy, input logic e_done);
      tests++;
      assert (en_reg_state_o === e_en) else begin
         fails++;
         $error("FAIL %s en_reg_state obs=%b exp=%b", tag, en_reg_state_o, e_en);
      end
      tests++;
      assert (data_sel_o === e_ds) else begin
         fails++;
         $error("FAIL %s data_sel obs=%b exp=%b", tag, data_sel_o, e_ds);
      end
      if (chk_round) begin
         tests++;
         assert (round_o === e_round) else begin
            fails++;
            $error("FAIL %s round obs=%0d exp=%0d", tag, round_o, e_round);
         end
      end
      tests++;
      assert (busy_o === e_busy) else begin
         fails++;
         $error("FAIL %s busy obs=%b exp=%b", tag, busy_o, e_busy);
      end
      tests++;
      assert (done_o === e_done) else begin
         fails++;
         $error("FAIL %s done obs=%b exp=%b", tag, done_o, e_done);
      end
      tests++;
      assert (perm_cnt_o === exp_cnt) else begin
         fails++;
         $error("FAIL %s perm_cnt obs=%0d exp=%0d", tag, perm_cnt_o, exp_cnt);
      end
   endtask

   // One isolated permutation from IDLE, checked cycle by cycle.
   task automatic run_perm(input logic m, input string tag);
      int n;
      logic [3:0] r0;
      n  = m ? 6 : 12;
      r0 = m ? 4'd6 : 4'd0;
      mode_i  = m;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         check(tag, 1'b1, (i != 0), 1'b1, 4'(r0 + 4'(i)), 1'b1, 1'b0);
         tick();
      end
      bump();
      check({tag, "_done"}, 1'b0, 1'b1, 1'b1, 4'd11, 1'b0, 1'b1);
      tick();
      check({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      #12;
      check("reset", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      #1 resetb_i = 1'b1;
      tick();
      check("post_reset_idle", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

      // pa and pb single runs
      run_perm(1'b0, "pa");
      run_perm(1'b1, "pb");

      // Back-to-back pa with start held for 30 edges
      mode_i  = 1'b0;
      start_i = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         int ph;
         tick();
         ph = (c - 1) % 13;
         if (c == 40) begin
            check("b2b_idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
         end else if (ph == 12) begin
            bump();
            check("b2b_done", 1'b0, 1'b1, 1'b1, 4'd11, 1'b0, 1'b1);
         end else begin
            check("b2b_run", 1'b1, (ph != 0), 1'b1, 4'(ph), 1'b1, 1'b0);
         end
         if (c == 30) start_i = 1'b0;
      end

      // start pulse and mode toggle mid-run are ignored
      mode_i  = 1'b0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("ign_run", 1'b1, (i != 0), 1'b1, 4'(i), 1'b1, 1'b0);
         if (i == 4) begin
            start_i = 1'b1;
            mode_i  = 1'b1;
         end else if (i == 5) begin
            start_i = 1'b0;
         end
         tick();
      end
      bump();
      check("ign_done", 1'b0, 1'b1, 1'b1, 4'd11, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ign_idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      end
      mode_i = 1'b0;

      // Asynchronous reset at round 7, then a clean pa run
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("abort_run", 1'b1, (i != 0), 1'b1, 4'(i), 1'b1, 1'b0);
         if (i < 7) tick();
      end
      #2 resetb_i = 1'b0;
      #1;
      exp_cnt = '0;
      check("abort_reset", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_hold", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      end
      #2 resetb_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_nodone", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      end
      run_perm(1'b0, "pa_after_abort");

      // Counter: five pb runs from a fresh reset
      #2 resetb_i = 1'b0;
      #1;
      exp_cnt = '0;
      check("cnt_reset", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      #2 resetb_i = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         run_perm(1'b1, "cnt_pb");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #100000;
      fails++;
      $display("FAIL timeout obs=running exp=finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
